// File: rtl/ddr_tx.sv
// rtl/ddr_tx.sv - DDR serial transmitter for HDR-DDR preamble, byte, parity and CRC words
//
// Purpose:
//   Serializes one transmit mode onto SDA, one bit per SCL edge (rising or
//   falling). Mode and data are sampled only when idle (READY). Bytes are
//   mirrored to the CRC block and folded into a 16-bit parity accumulator.
//
// Ports:
//   i_sys_clk, i_sys_rst            - clock, synchronous active-high reset
//   i_sclgen_scl                    - SCL level (monitor only, not used)
//   i_sclgen_scl_pos_edge/neg_edge  - one-cycle SCL edge pulses
//   i_ddrccc_tx_en, i_ddrccc_tx_mode- transmit enable and requested mode
//   i_regf_tx_data                  - byte to send in BYTE mode
//   i_crc_value                     - CRC5 sent in CRC mode
//   o_sdahnd_tx_sda                 - serial data out
//   o_ddrccc_tx_mode_done           - pulse with the last bit of a mode
//   o_ddrccc_error                  - pulse on an illegal mode request
//   o_crc_en, o_crc_data_out        - byte strobe and byte for the CRC block

module ddr_tx (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_sclgen_scl,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_ddrccc_tx_en,
  input  logic [3:0] i_ddrccc_tx_mode,
  input  logic [7:0] i_regf_tx_data,
  input  logic [4:0] i_crc_value,
  output logic       o_sdahnd_tx_sda,
  output logic       o_ddrccc_tx_mode_done,
  output logic       o_ddrccc_error,
  output logic       o_crc_en,
  output logic [7:0] o_crc_data_out
);

  typedef enum logic [1:0] {READY, SHIFT, ABORT} state_t;

  localparam logic [3:0] MODE_IDLE   = 4'd0;
  localparam logic [3:0] MODE_PRE_10 = 4'd1;
  localparam logic [3:0] MODE_PRE_01 = 4'd2;
  localparam logic [3:0] MODE_BYTE   = 4'd3;
  localparam logic [3:0] MODE_PARITY = 4'd4;
  localparam logic [3:0] MODE_CRC    = 4'd5;

  state_t      state_q, state_nxt;
  logic [3:0]  mode_q, mode_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [8:0]  sr_q, sr_nxt;
  logic [15:0] acc_q, acc_nxt;
  logic        sda_q, sda_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        crc_en_q, crc_en_nxt;
  logic [7:0]  crc_data_q, crc_data_nxt;

  logic        edge_ev;
  logic        mode_legal;
  logic        pa1, pa0;
  logic [8:0]  frame;
  logic [3:0]  last_idx;
  logic        unused_ok;

  assign unused_ok  = i_sclgen_scl;
  assign edge_ev    = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign mode_legal = (i_ddrccc_tx_mode != MODE_IDLE) && (i_ddrccc_tx_mode <= MODE_CRC);

  // Odd-indexed accumulator bits give PA1; even-indexed bits, inverted, give PA0.
  assign pa1 = ^(acc_q & 16'hAAAA);
  assign pa0 = ~(^(acc_q & 16'h5555));

  // Bit sequence of the requested mode, left-aligned so frame[8] goes out first.
  always_comb begin
    frame = 9'h000;
    case (i_ddrccc_tx_mode)
      MODE_PRE_10: frame = 9'b10_0000000;
      MODE_PRE_01: frame = 9'b01_0000000;
      MODE_BYTE:   frame = {i_regf_tx_data, 1'b0};
      MODE_PARITY: frame = {pa1, pa0, 7'b0000000};
      MODE_CRC:    frame = {4'b1100, i_crc_value};
      default:     frame = 9'h000;
    endcase
  end

  // Counter value (bits already sent) at which the next edge sends the last bit.
  always_comb begin
    last_idx = 4'd0;
    case (mode_q)
      MODE_PRE_10, MODE_PRE_01, MODE_PARITY: last_idx = 4'd1;
      MODE_BYTE:                             last_idx = 4'd7;
      MODE_CRC:                              last_idx = 4'd8;
      default:                               last_idx = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt    = state_q;
    mode_nxt     = mode_q;
    cnt_nxt      = cnt_q;
    sr_nxt       = sr_q;
    acc_nxt      = acc_q;
    sda_nxt      = sda_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    crc_en_nxt   = 1'b0;
    crc_data_nxt = crc_data_q;
    case (state_q)
      READY: begin
        if (!i_ddrccc_tx_en) begin
          sda_nxt = 1'b1;
        end else if (edge_ev) begin
          if (mode_legal) begin
            mode_nxt  = i_ddrccc_tx_mode;
            sda_nxt   = frame[8];
            sr_nxt    = {frame[7:0], 1'b0};
            cnt_nxt   = 4'd1;
            state_nxt = SHIFT;
            if (i_ddrccc_tx_mode == MODE_BYTE) begin
              crc_en_nxt   = 1'b1;
              crc_data_nxt = i_regf_tx_data;
              acc_nxt      = {acc_q[7:0], i_regf_tx_data};
            end
          end else begin
            sda_nxt = 1'b1;
            err_nxt = (i_ddrccc_tx_mode != MODE_IDLE);
          end
        end
      end
      SHIFT: begin
        if (!i_ddrccc_tx_en) begin
          sda_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          mode_nxt  = MODE_IDLE;
          sr_nxt    = 9'h000;
          state_nxt = ABORT;
        end else if (edge_ev) begin
          sda_nxt = sr_q[8];
          sr_nxt  = {sr_q[7:0], 1'b0};
          cnt_nxt = cnt_q + 4'd1;
          if (cnt_q == last_idx) begin
            done_nxt  = 1'b1;
            cnt_nxt   = 4'd0;
            mode_nxt  = MODE_IDLE;
            state_nxt = READY;
            if (mode_q == MODE_PARITY) acc_nxt = 16'h0000;
          end
        end
      end
      ABORT: begin
        sda_nxt   = 1'b1;
        state_nxt = READY;
      end
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= READY;
      mode_q     <= MODE_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 9'h000;
      acc_q      <= 16'h0000;
      sda_q      <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_en_q   <= 1'b0;
      crc_data_q <= 8'h00;
    end else begin
      state_q    <= state_nxt;
      mode_q     <= mode_nxt;
      cnt_q      <= cnt_nxt;
      sr_q       <= sr_nxt;
      acc_q      <= acc_nxt;
      sda_q      <= sda_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      crc_en_q   <= crc_en_nxt;
      crc_data_q <= crc_data_nxt;
    end
  end

  assign o_sdahnd_tx_sda       = sda_q;
  assign o_ddrccc_tx_mode_done = done_q;
  assign o_ddrccc_error        = err_q;
  assign o_crc_en              = crc_en_q;
  assign o_crc_data_out        = crc_data_q;

endmodule

// File: tb/tb_ddr_tx.sv
// tb/tb_ddr_tx.sv - self-checking bench for ddr_tx with a queue-based reference model

module tb_ddr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       pos;
  logic       neg;
  logic       en;
  logic [3:0] mode;
  logic [7:0] data;
  logic [4:0] crc;
  logic       sda;
  logic       done;
  logic       err;
  logic       crc_en;
  logic [7:0] crc_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  int       n_crc = 0;
  int       n_done_seen = 0;
  logic [7:0] crc_log[$];

  always #10 clk = ~clk;

  ddr_tx dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_sclgen_scl          (scl),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_ddrccc_tx_en        (en),
    .i_ddrccc_tx_mode      (mode),
    .i_regf_tx_data        (data),
    .i_crc_value           (crc),
    .o_sdahnd_tx_sda       (sda),
    .o_ddrccc_tx_mode_done (done),
    .o_ddrccc_error        (err),
    .o_crc_en              (crc_en),
    .o_crc_data_out        (crc_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a mode becomes a list of bits; each edge pops one.
  bit         m_busy = 0;
  bit         m_abort = 0;
  bit         q[$];
  logic [3:0] m_cur;
  logic [15:0] m_acc;
  logic       m_sda, m_done, m_err, m_crc_en;
  logic [7:0] m_crc_data;

  always @(posedge clk) begin
    logic ev;
    ev = pos | neg;
    m_done = 0; m_err = 0; m_crc_en = 0;
    if (rst) begin
      m_busy = 0; m_abort = 0; q.delete();
      m_sda = 1; m_crc_data = 8'h00; m_acc = 16'h0000; m_cur = 4'd0;
    end else if (m_abort) begin
      m_abort = 0; m_sda = 1;
    end else if (m_busy) begin
      if (!en) begin
        m_busy = 0; q.delete(); m_sda = 1; m_abort = 1;
      end else if (ev) begin
        m_sda = q.pop_front();
        if (q.size() == 0) begin
          m_done = 1; m_busy = 0;
          if (m_cur == 4'd4) m_acc = 16'h0000;
        end
      end
    end else if (!en) begin
      m_sda = 1;
    end else if (ev) begin
      if (mode == 4'd0) m_sda = 1;
      else if (mode > 4'd5) begin m_err = 1; m_sda = 1; end
      else begin
        q.delete();
        case (mode)
          4'd1: begin q.push_back(1); q.push_back(0); end
          4'd2: begin q.push_back(0); q.push_back(1); end
          4'd3: for (int i = 7; i >= 0; i--) q.push_back(data[i]);
          4'd4: begin
            q.push_back(^(m_acc & 16'hAAAA));
            q.push_back(!(^(m_acc & 16'h5555)));
          end
          default: begin
            q.push_back(1); q.push_back(1); q.push_back(0); q.push_back(0);
            for (int i = 4; i >= 0; i--) q.push_back(crc[i]);
          end
        endcase
        if (mode == 4'd3) begin
          m_crc_en = 1; m_crc_data = data; m_acc = {m_acc[7:0], data};
        end
        m_cur = mode;
        m_sda = q.pop_front();
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_sda", sda, m_sda);
      check("model_done", done, m_done);
      check("model_err", err, m_err);
      check("model_crc_en", crc_en, m_crc_en);
      check("model_crc_data", crc_data, m_crc_data);
      if (crc_en === 1'b1) begin n_crc++; crc_log.push_back(crc_data); end
      if (done === 1'b1) n_done_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_edge();
    scl = ~scl;
    if (scl) pos = 1; else neg = 1;
    @(posedge clk); #1;
    pos = 0; neg = 0;
  endtask

  task automatic run_edges(input int n, output logic [15:0] bits, output int dones);
    bits = 16'h0; dones = 0;
    for (int i = 0; i < n; i++) begin
      pulse_edge();
      bits = {bits[14:0], sda};
      if (done) dones++;
      idle(1);
    end
  endtask

  logic [15:0] b;
  int          d;
  int          r;

  initial begin
    rst = 1; scl = 0; pos = 0; neg = 0; en = 0; mode = 4'd0; data = 8'h00; crc = 5'd0;
    idle(2);
    chk_on = 1;
    check("rst_sda", sda, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_crc_en", crc_en, 0);
    check("rst_crc_data", crc_data, 8'h00);
    rst = 0;
    idle(1);

    // PRE_10, then SDA must hold the last bit with no edges
    en = 1; mode = 4'd1;
    run_edges(2, b, d);
    check("pre10_bits", b[1:0], 2'b10);
    check("pre10_done", d, 1);
    idle(3);
    check("pre10_hold", sda, 0);

    // BYTE 0xAD, BYTE 0xCA back to back, then PARITY
    n_crc = 0; crc_log.delete();
    mode = 4'd3; data = 8'hAD;
    run_edges(8, b, d);
    check("byte_ad_bits", b[7:0], 8'hAD);
    check("byte_ad_done", d, 1);
    data = 8'hCA;
    run_edges(8, b, d);
    check("byte_ca_bits", b[7:0], 8'hCA);
    check("byte_ca_done", d, 1);
    check("crc_en_count", n_crc, 2);
    if (crc_log.size() == 2) begin
      check("crc_data0", crc_log[0], 8'hAD);
      check("crc_data1", crc_log[1], 8'hCA);
    end else check("crc_log_size", crc_log.size(), 2);
    mode = 4'd4;
    run_edges(2, b, d);
    check("parity_adca", b[1:0], 2'b00);
    check("parity_done", d, 1);

    // single byte with zero-filled acc, then parity of cleared acc
    mode = 4'd3; data = 8'h03;
    run_edges(8, b, d);
    mode = 4'd4;
    run_edges(2, b, d);
    check("parity_03", b[1:0], 2'b10);
    run_edges(2, b, d);
    check("parity_empty", b[1:0], 2'b01);

    // CRC word
    mode = 4'd5; crc = 5'b10110;
    run_edges(9, b, d);
    check("crc_bits", b[8:0], 9'b110010110);
    check("crc_done", d, 1);

    // abort after 3 bits of 0xFF
    mode = 4'd3; data = 8'hFF;
    run_edges(3, b, d);
    check("abort_pre_bits", b[2:0], 3'b111);
    en = 0;
    idle(1);
    check("abort_sda", sda, 1);
    d = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) d++;
      idle(1);
    end
    check("abort_no_done", d, 0);
    en = 1;
    idle(1);

    // illegal mode, then a legal one
    mode = 4'hF;
    pulse_edge();
    check("illegal_err", err, 1);
    check("illegal_sda", sda, 1);
    check("illegal_no_done", done, 0);
    idle(1);
    check("illegal_err_clear", err, 0);
    mode = 4'd2;
    run_edges(2, b, d);
    check("pre01_bits", b[1:0], 2'b01);
    check("pre01_done", d, 1);

    // IDLE mode edge and en=0 edge keep SDA high
    mode = 4'd0;
    pulse_edge();
    check("idle_sda", sda, 1);
    en = 0; mode = 4'd2;
    pulse_edge();
    check("en0_sda", sda, 1);
    idle(2);

    // reset in the middle of a BYTE, coinciding with an edge
    en = 1; mode = 4'd3; data = 8'h5A;
    run_edges(4, b, d);
    rst = 1;
    pulse_edge();
    rst = 0;
    check("midrst_sda", sda, 1);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_crc_en", crc_en, 0);
    check("midrst_crc_data", crc_data, 8'h00);
    mode = 4'd1;
    run_edges(2, b, d);
    check("postrst_bits", b[1:0], 2'b10);
    check("postrst_done", d, 1);

    // randomized traffic against the model
    n_done_seen = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = (($urandom % 500) == 0);
      if (en) begin
        if (($urandom % 60) == 0) en = 0;
      end else if (($urandom % 4) == 0) en = 1;
      if (($urandom % 8) == 0) begin
        r = int'($urandom % 20);
        if (r < 16) mode = 4'(1 + (r % 5));
        else if (r < 18) mode = 4'd0;
        else mode = 4'(6 + ($urandom % 10));
      end
      data = 8'($urandom);
      crc  = 5'($urandom);
      if (($urandom % 3) == 0) begin
        scl = ~scl; pos = scl; neg = ~scl;
      end else begin
        pos = 0; neg = 0;
      end
      @(posedge clk); #1;
    end
    rst = 0; pos = 0; neg = 0;
    idle(2);
    check("random_done_seen", (n_done_seen > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_tx.md
DDR_TX -- requirements
Module: ddr_tx

Interface
REQ-001 SHALL have `i_sys_clk  in  1`: system clock (50 MHz); the only clock.
REQ-002 SHALL have `i_sys_rst  in  1`: reset, synchronous, active-high.
REQ-003 SHALL have `i_sclgen_scl  in  1`: SCL level from scl_generation (monitor only).
REQ-004 SHALL have `i_sclgen_scl_pos_edge  in  1`: one-cycle pulse per SCL rising edge.
REQ-005 SHALL have `i_sclgen_scl_neg_edge  in  1`: one-cycle pulse per SCL falling edge.
REQ-006 SHALL have `i_ddrccc_tx_en  in  1`: transmit enable from the DDR CCC controller.
REQ-007 SHALL have `i_ddrccc_tx_mode  in  4`: requested TX mode (see REQ-012).
REQ-008 SHALL have `i_regf_tx_data  in  8`: data byte from the register file.
REQ-009 SHALL have `i_crc_value  in  5`: CRC5 from the CRC block.
REQ-010 SHALL have these outputs:
- `o_sdahnd_tx_sda  out  1`: serial data to the SDA handler.
- `o_ddrccc_tx_mode_done  out  1`: one-cycle mode-complete pulse.
- `o_ddrccc_error  out  1`: one-cycle pulse on an illegal mode.
- `o_crc_en  out  1`: one-cycle byte-valid strobe to CRC.
- `o_crc_data_out  out  8`: byte captured for CRC.

Function
REQ-011 SHALL define an edge event as `pos_edge OR neg_edge` in a cycle. DDR operation: exactly one bit is advanced per edge event.
REQ-012 SHALL support the following modes:
- 0000 IDLE: SDA=1, 0 bits.
- 0001 PRE_10: bits 1,0.
- 0010 PRE_01: bits 0,1.
- 0011 BYTE: 8 bits, MSB first.
- 0100 PARITY: bits PA1, PA0.
- 0101 CRC: bits 1,1,0,0 followed by `i_crc_value[4:0]` MSB first (9 bits).
REQ-013 SHALL use FSM states READY, SHIFT and ABORT. Mode and data are sampled only in READY.
REQ-014 SHALL, in READY, on the first edge event with en=1 and a non-IDLE legal mode:
- latch the mode;
- load the shift register;
- register the first bit to SDA (visible the next cycle);
- move to SHIFT with the internal bit counter set to 1.
REQ-015 SHALL, in SHIFT, register the next bit and increment the counter on each edge event. The counter is internal; no external bit count is used.
REQ-016 SHALL, on the edge event that registers the last bit of the mode, pulse `o_ddrccc_tx_mode_done` in the following cycle, concurrently with that bit appearing on SDA, and return to READY.
REQ-017 SHALL allow back-to-back modes: the next edge event after done starts the newly presented mode with no gap bit.
REQ-018 SHALL hold SDA at the last driven value between edge events and while en=1 with no edges.
REQ-019 SHALL, on BYTE capture, register `o_crc_data_out` = `i_regf_tx_data` and pulse `o_crc_en` for one cycle, and shift the byte into a 16-bit parity accumulator: `acc = {acc[7:0], byte}`.
REQ-020 SHALL compute parity from acc:
- PA1 = XOR of acc[15,13,11,9,7,5,3,1];
- PA0 = XOR of acc[14,12,10,8,6,4,2,0] XOR 1.
If fewer than two bytes have been captured, the zero-filled acc is used.
REQ-021 SHALL clear acc to 0 when PARITY mode completes.
REQ-022 SHALL, for an illegal mode (0110–1111) sampled in READY with en=1 on an edge event, pulse `o_ddrccc_error` for one cycle, keep SDA=1, give no done, and stay in READY.
REQ-023 SHALL, if en deasserts in SHIFT, abort:
- SDA=1 the next cycle;
- counter and latched mode cleared;
- no done;
- return to READY (via ABORT, one cycle);
- acc preserved.
REQ-024 SHALL ignore mode changes while in SHIFT; the latched mode governs until completion or abort.
REQ-025 SHALL take no action on an edge event while en=0 and shall keep SDA=1.

Reset
REQ-026 SHALL, when `i_sys_rst`=1 at a clock edge, set:
- FSM = READY, counter = 0, acc = 0;
- `o_sdahnd_tx_sda` = 1;
- `o_ddrccc_tx_mode_done` = 0, `o_ddrccc_error` = 0, `o_crc_en` = 0;
- `o_crc_data_out` = 8'h00.
REQ-027 SHALL, on reset assertion mid-transfer, override all other behaviour in that cycle.

Verification
REQ-028 SHALL cover: reset asserted mid-BYTE → next cycle SDA=1, all pulses 0, FSM READY.
REQ-029 SHALL cover: en=1, mode 0001 → SDA 1 after edge 1, 0 after edge 2; exactly one done pulse.
REQ-030 SHALL cover: BYTE 0xAD then BYTE 0xCA → SDA 1,0,1,0,1,1,0,1,1,1,0,0,1,0,1,0; o_crc_en pulses twice with data 0xAD, 0xCA; then PARITY → SDA 0,0.
REQ-031 SHALL cover: CRC mode with i_crc_value=5'b10110 → SDA 1,1,0,0,1,0,1,1,0; done after the 9th edge.
REQ-032 SHALL cover: en dropped after 3 bits of BYTE 0xFF → SDA=1 next cycle; no done.
REQ-033 SHALL cover: mode 4'b1111 with en=1 → one error pulse; SDA stays 1; a following legal mode completes normally.
